// File: rtl/mem_arb_nch_if.sv
// mem_arb_nch_if
//   Bundle of the per-channel request/response signals of mem_arb_nch.
//   All per-channel fields are packed flat, channel i in slice i.
//   Ports (from the requester's point of view, modport master):
//     req      out NUM_CH             access request, held until granted
//     write    out NUM_CH             1 = write, 0 = read
//     addr     out NUM_CH*ADDR_WIDTH  channel address lanes
//     data_in  out NUM_CH*DATA_WIDTH  channel write-data lanes
//     gnt      in  NUM_CH             one-hot grant (combinational)
//     rvalid   in  NUM_CH             read data valid, one cycle after grant
//     data_out in  NUM_CH*DATA_WIDTH  per-channel read-data lanes
//     err      in  NUM_CH             out-of-range access flag
//   The memory side uses modport slave (directions reversed).
interface mem_arb_nch_if #(
   parameter int NUM_CH     = 2,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
);
   logic [NUM_CH-1:0]            req;
   logic [NUM_CH-1:0]            write;
   logic [NUM_CH*ADDR_WIDTH-1:0] addr;
   logic [NUM_CH*DATA_WIDTH-1:0] data_in;
   logic [NUM_CH-1:0]            gnt;
   logic [NUM_CH-1:0]            rvalid;
   logic [NUM_CH*DATA_WIDTH-1:0] data_out;
   logic [NUM_CH-1:0]            err;

   modport master (
      output req, write, addr, data_in,
      input  gnt, rvalid, data_out, err
   );

   modport slave (
      input  req, write, addr, data_in,
      output gnt, rvalid, data_out, err
   );
endinterface

// File: rtl/mem_arb_nch.sv
// mem_arb_nch
//   N-channel single-array memory. A round-robin arbiter grants at most one
//   channel per clock; writes commit on the grant edge, reads return on the
//   granted channel's own lane one cycle later. Out-of-range accesses are
//   dropped and flagged on err.
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset
//     bus    mem_arb_nch_if.slave (req/write/addr/data_in in,
//            gnt/rvalid/data_out/err out)
module mem_arb_nch #(
   parameter int NUM_CH     = 2,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arb_nch_if.slave  bus
);
   localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

   // Storage: not reset, contents undefined until written.
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_word_q;

   logic [PTR_W-1:0]             ptr_q, ptr_d;
   logic [NUM_CH-1:0]            rvalid_q, rvalid_d;
   logic [NUM_CH-1:0]            err_q, err_d;
   logic                         rd_oor_q, rd_oor_d;
   logic [NUM_CH*DATA_WIDTH-1:0] hold_q, hold_d;
   logic [NUM_CH*DATA_WIDTH-1:0] data_out;

   logic [NUM_CH-1:0]     gnt;
   logic [PTR_W-1:0]      gnt_idx;
   logic                  gnt_any;
   int                    idx;
   logic [ADDR_WIDTH-1:0] addr_sel;
   logic [DATA_WIDTH-1:0] data_sel;
   logic                  wr_sel;
   logic                  in_range;
   logic                  do_wr;
   logic                  do_rd;

   // Round-robin search starting at ptr; first requester wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int off = 0; off < NUM_CH; off++) begin
         idx = int'(ptr_q) + off;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!gnt_any && bus.req[idx]) begin
            gnt_any      = 1'b1;
            gnt_idx      = PTR_W'(idx);
            gnt[idx]     = 1'b1;
         end
      end
   end

   // Granted channel's request fields.
   always_comb begin
      addr_sel = bus.addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      data_sel = bus.data_in[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      wr_sel   = bus.write[gnt_idx];
      in_range = ({1'b0, addr_sel} < DEPTH_L);
      do_wr    = gnt_any & wr_sel & in_range;
      do_rd    = gnt_any & ~wr_sel & in_range;
   end

   // Block RAM with registered read port. rst_n gates accesses so nothing
   // executes while reset is held; the array itself is never cleared.
   always_ff @(posedge clk) begin
      if (rst_n && do_wr) mem[addr_sel[MEM_AW-1:0]] <= data_sel;
      if (rst_n && do_rd) rd_word_q <= mem[addr_sel[MEM_AW-1:0]];
   end

   // Next-state for pointer and response flags.
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any) begin
         if (gnt_idx == PTR_W'(NUM_CH-1)) ptr_d = '0;
         else                             ptr_d = gnt_idx + 1'b1;
      end
      rvalid_d = wr_sel ? '0 : gnt;
      err_d    = in_range ? '0 : gnt;
      rd_oor_d = ~in_range;
      // Each lane keeps whatever it last presented.
      hold_d   = data_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q    <= '0;
         rvalid_q <= '0;
         err_q    <= '0;
         rd_oor_q <= 1'b0;
         hold_q   <= '0;
      end else begin
         ptr_q    <= ptr_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rd_oor_q <= rd_oor_d;
         hold_q   <= hold_d;
      end
   end

   // Only one lane can have rvalid at a time, so the single RAM output
   // register feeds every lane; out-of-range reads present zero.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
         assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] =
            rvalid_q[gi] ? (rd_oor_q ? '0 : rd_word_q)
                         : hold_q[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   assign bus.gnt      = gnt;
   assign bus.rvalid   = rvalid_q;
   assign bus.err      = err_q;
   assign bus.data_out = data_out;
endmodule

// File: tb/tb_mem_arb_nch.sv
module tb_mem_arb_nch;
   localparam int NCH = 4;
   localparam int DW  = 8;
   localparam int AW  = 5;
   localparam int DEP = 20;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   rv_cnt [NCH];

   typedef struct {
      int        lane;
      bit        rd;
      bit        er;
      logic [7:0] data;
   } exp_t;
   exp_t sb_q[$];
   exp_t mon_e;

   mem_arb_nch_if #(.NUM_CH(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   mem_arb_nch #(.NUM_CH(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end else begin
         $display("ok   %s: %h", nm, act);
      end
   endtask

   task automatic set_lane(input int lane, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.addr[lane*AW +: AW]    = a;
      bus.data_in[lane*DW +: DW] = d;
   endtask

   task automatic push(input int lane, input bit rd, input bit er, input logic [7:0] d);
      exp_t e;
      e.lane = lane; e.rd = rd; e.er = er; e.data = d;
      sb_q.push_back(e);
   endtask

   // Inputs are already applied (just after a falling edge); check gnt,
   // let the rising edge pass, return on the next falling edge.
   task automatic step(input string nm, input logic [NCH-1:0] exp_gnt);
      #1;
      check(nm, 32'(bus.gnt), 32'(exp_gnt));
      @(negedge clk);
   endtask

   // Monitor: every lane response is matched against the scoreboard.
   always @(negedge clk) begin
      if (bus.rvalid != '0 || bus.err != '0) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected: rvalid=%b err=%b expected no response",
                     bus.rvalid, bus.err);
         end else begin
            mon_e = sb_q.pop_front();
            if (bus.rvalid !== (mon_e.rd ? 4'(1 << mon_e.lane) : 4'b0) ||
                bus.err    !== (mon_e.er ? 4'(1 << mon_e.lane) : 4'b0) ||
                (mon_e.rd && bus.data_out[mon_e.lane*DW +: DW] !== mon_e.data)) begin
               errors++;
               $display("FAIL resp_lane%0d: rvalid=%b err=%b data=%h expected rd=%0d er=%0d data=%h",
                        mon_e.lane, bus.rvalid, bus.err, bus.data_out[mon_e.lane*DW +: DW],
                        mon_e.rd, mon_e.er, mon_e.data);
            end else begin
               $display("ok   resp_lane%0d: rvalid=%b err=%b data=%h",
                        mon_e.lane, bus.rvalid, bus.err, bus.data_out[mon_e.lane*DW +: DW]);
            end
         end
         for (int i = 0; i < NCH; i++) if (bus.rvalid[i]) rv_cnt[i]++;
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < NCH; i++) rv_cnt[i] = 0;
      rst_n        = 1'b0;
      bus.req      = '0;
      bus.write    = '0;
      bus.addr     = '0;
      bus.data_in  = '0;
      repeat (2) @(negedge clk);
      check("reset_rvalid", 32'(bus.rvalid), 32'h0);
      check("reset_err", 32'(bus.err), 32'h0);
      check("reset_data_out", bus.data_out, 32'h0);
      rst_n = 1'b1;

      // Single channel write then read on ch0.
      set_lane(0, 5'd3, 8'hA5);
      bus.req = 4'b0001; bus.write = 4'b0001;
      step("single_wr_gnt", 4'b0001);
      bus.write = 4'b0000;
      push(0, 1, 0, 8'hA5);
      step("single_rd_gnt", 4'b0001);
      bus.req = 4'b0000;
      step("idle_gnt", 4'b0000);
      check("hold_data_out0", 32'(bus.data_out[0 +: DW]), 32'hA5);

      // Contention with ptr=1: ch1 write wins, ch0 read then sees new data.
      set_lane(1, 5'd7, 8'h3C);
      set_lane(0, 5'd7, 8'h00);
      bus.req = 4'b0011; bus.write = 4'b0010;
      step("contend_gnt1", 4'b0010);
      bus.req = 4'b0001; bus.write = 4'b0000;
      push(0, 1, 0, 8'h3C);
      step("contend_gnt0", 4'b0001);
      bus.req = 4'b0000;
      step("contend_idle", 4'b0000);

      // Reset lands between a read's grant edge and its rvalid sample.
      set_lane(2, 5'd3, 8'h00);
      bus.req = 4'b0100;
      #1;
      check("rst_pre_gnt", 32'(bus.gnt), 32'h4);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      set_lane(0, 5'd3, 8'h00);
      set_lane(1, 5'd7, 8'h00);
      set_lane(3, 5'd7, 8'h00);
      bus.req = 4'b1111;
      #1;
      check("rst_mid_rvalid", 32'(bus.rvalid), 32'h0);
      check("rst_mid_err", 32'(bus.err), 32'h0);
      check("rst_mid_data_out", bus.data_out, 32'h0);
      check("rst_mid_gnt", 32'(bus.gnt), 32'h1);
      for (int i = 0; i < NCH; i++) rv_cnt[i] = 0;
      @(negedge clk);
      rst_n = 1'b1;

      // Round robin: all four hold req for eight cycles.
      for (int c = 0; c < 8; c++) begin
         push(c % NCH, 1, 0, ((c % 2) == 0) ? 8'hA5 : 8'h3C);
         step($sformatf("rr_gnt_c%0d", c), 4'(1 << (c % NCH)));
      end
      bus.req = 4'b0000;
      step("rr_idle", 4'b0000);
      for (int i = 0; i < NCH; i++)
         check($sformatf("rr_rvalid_count%0d", i), 32'(rv_cnt[i]), 32'd2);

      // Out-of-range accesses at addr 25 with DEPTH=20; addr 19 untouched.
      set_lane(3, 5'd19, 8'h77);
      bus.req = 4'b1000; bus.write = 4'b1000;
      step("oor_pre_wr19", 4'b1000);
      set_lane(2, 5'd25, 8'hFF);
      bus.req = 4'b0100; bus.write = 4'b0100;
      push(2, 0, 1, 8'h00);
      step("oor_wr25", 4'b0100);
      bus.write = 4'b0000;
      push(2, 1, 1, 8'h00);
      step("oor_rd25", 4'b0100);
      set_lane(2, 5'd19, 8'h00);
      push(2, 1, 0, 8'h77);
      step("oor_rd19", 4'b0100);
      bus.req = 4'b0000;
      step("oor_idle", 4'b0000);

      // Full sweep: ch0 writes every word, ch1 reads every word back.
      for (int a = 0; a < DEP; a++) begin
         set_lane(0, AW'(a), 8'(a) ^ 8'h5A);
         bus.req = 4'b0001; bus.write = 4'b0001;
         step($sformatf("sweep_wr%0d", a), 4'b0001);
      end
      for (int a = 0; a < DEP; a++) begin
         set_lane(1, AW'(a), 8'h00);
         bus.req = 4'b0010; bus.write = 4'b0000;
         push(1, 1, 0, 8'(a) ^ 8'h5A);
         step($sformatf("sweep_rd%0d", a), 4'b0010);
      end
      bus.req = 4'b0000;
      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
